// File: rtl/aes_key_expand.sv
// ---------------------------------------------------------------------------
// aes_key_expand
//
// Iterative AES-128 key schedule. On an accepted start the cipher key is
// latched and the 11 round keys are streamed out one per clock, round key 0
// first. The next key is produced combinationally from the current one with
// four S-box instances, so a full expansion takes 11 cycles. The round
// constant comes from a register stepped by xtime, not from a lookup table.
//
// Ports
//   clk         single clock, all state changes on the rising edge
//   rst         synchronous, active-high reset
//   start       expansion request, only looked at while idle
//   cipher_key  AES-128 key, w0 = [127:96] ... w3 = [31:0]
//   busy        high while an expansion is running
//   rk_valid    round_key / rk_idx valid this cycle
//   rk_idx      round-key index 0..10
//   round_key   round key rk_idx, same word order as cipher_key
//   done        single-cycle pulse with rk_idx = 10
//   rk_rd_idx   (AES_KEY_STORE_EN only) read index into the key store
//   rk_rd_data  (AES_KEY_STORE_EN only) stored key, 0 for index 11..15
//
// Optional feature: define AES_KEY_STORE_EN to add an 11 x 128 store that
// keeps every streamed round key for random-access reads.
// ---------------------------------------------------------------------------

// AES S-box computed as GF(2^8) inverse followed by the affine map.
module aes_sbox (
   input  logic [7:0] data,
   output logic [7:0] sub
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] a2, a4, a8, a16, a32, a64, a128;
   logic [7:0] inv;

   // inverse = data^254 = data^(2+4+8+16+32+64+128); zero maps to zero
   assign a2   = gf_mul(data, data);
   assign a4   = gf_mul(a2, a2);
   assign a8   = gf_mul(a4, a4);
   assign a16  = gf_mul(a8, a8);
   assign a32  = gf_mul(a16, a16);
   assign a64  = gf_mul(a32, a32);
   assign a128 = gf_mul(a64, a64);
   assign inv  = gf_mul(gf_mul(gf_mul(a2, a4), gf_mul(a8, a16)),
                        gf_mul(gf_mul(a32, a64), a128));

   assign sub = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

module aes_key_expand (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] cipher_key,
   output logic         busy,
   output logic         rk_valid,
   output logic [3:0]   rk_idx,
   output logic [127:0] round_key,
   output logic         done
`ifdef AES_KEY_STORE_EN
   ,
   input  logic [3:0]   rk_rd_idx,
   output logic [127:0] rk_rd_data
`endif
);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] EXPAND = 1'b1;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   logic [0:0]   state;
   logic [7:0]   rcon;
   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  rot, sub, temp;
   logic [31:0]  n0, n1, n2, n3;
   logic [127:0] next_key;

   // ---- next-key datapath (combinational from the current round key) ----
   assign {w0, w1, w2, w3} = round_key;
   assign rot = {w3[23:0], w3[31:24]};

   aes_sbox u_sbox3 (.data(rot[31:24]), .sub(sub[31:24]));
   aes_sbox u_sbox2 (.data(rot[23:16]), .sub(sub[23:16]));
   aes_sbox u_sbox1 (.data(rot[15:8]),  .sub(sub[15:8]));
   aes_sbox u_sbox0 (.data(rot[7:0]),   .sub(sub[7:0]));

   assign temp     = sub ^ {rcon, 24'h000000};
   assign n0       = w0 ^ temp;
   assign n1       = w1 ^ n0;
   assign n2       = w2 ^ n1;
   assign n3       = w3 ^ n2;
   assign next_key = {n0, n1, n2, n3};

   // ---- control and round-key register ----
   // The cipher key is only read on the accepting edge, so later changes on
   // cipher_key cannot disturb a running expansion. In the rk_idx = 10 cycle
   // the FSM returns to IDLE without sampling start, which forces the single
   // idle cycle between back-to-back expansions.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rk_idx    <= 4'd0;
         round_key <= '0;
         rcon      <= 8'h01;
      end else if (state == IDLE) begin
         if (start) begin
            state     <= EXPAND;
            round_key <= cipher_key;
            rk_idx    <= 4'd0;
            rcon      <= 8'h01;
         end
      end else begin
         if (rk_idx == 4'd10) begin
            state <= IDLE;
         end else begin
            round_key <= next_key;
            rk_idx    <= rk_idx + 4'd1;
            rcon      <= xtime(rcon);
         end
      end
   end

   assign busy     = (state == EXPAND);
   assign rk_valid = busy;
   assign done     = busy && (rk_idx == 4'd10);

`ifdef AES_KEY_STORE_EN
   logic [127:0] store [11];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 11; i++) store[i] <= '0;
      end else if (rk_valid && (rk_idx <= 4'd10)) begin
         store[rk_idx] <= round_key;
      end
   end

   assign rk_rd_data = (rk_rd_idx <= 4'd10) ? store[rk_rd_idx] : '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// ---------------------------------------------------------------------------
// tb_aes_key_expand
//
// Bench for aes_key_expand. A reference key schedule (S-box generated with
// the multiply-by-3 / divide-by-3 walk) feeds a scoreboard: each accepted
// start pushes the 11 expected round keys, and a negedge monitor pops and
// compares them while rk_valid is high. A table of published vectors is
// checked on top of that, followed by hand-written corner-case sequences.
// Define AES_KEY_STORE_EN to also exercise the key store.
// ---------------------------------------------------------------------------
module tb_aes_key_expand;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] cipher_key;
   logic         busy;
   logic         rk_valid;
   logic [3:0]   rk_idx;
   logic [127:0] round_key;
   logic         done;
`ifdef AES_KEY_STORE_EN
   logic [3:0]   rk_rd_idx;
   logic [127:0] rk_rd_data;
`endif

   always #5 clk = ~clk;

   aes_key_expand dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .cipher_key (cipher_key),
      .busy       (busy),
      .rk_valid   (rk_valid),
      .rk_idx     (rk_idx),
      .round_key  (round_key),
      .done       (done)
`ifdef AES_KEY_STORE_EN
      ,
      .rk_rd_idx  (rk_rd_idx),
      .rk_rd_data (rk_rd_data)
`endif
   );

   typedef struct {
      logic [3:0]   idx;
      logic [127:0] key;
   } exp_t;

   typedef struct {
      logic [127:0] key;
      logic [127:0] rk1;
      logic [127:0] rk10;
   } vec_t;

   localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   exp_t         sbq [$];
   vec_t         vecs [2];
   logic [7:0]   sbox_t [256];
   logic [7:0]   rcon_t [10];
   logic [127:0] cap [11];
   logic [127:0] m_k;
   int           m_cnt = 0;
   int           n_err = 0;
   int           n_chk = 0;
   bit           mon_en = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox_t[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox_t[0] = 8'h63;
   endtask

   function automatic logic [127:0] model_next(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
      {w0, w1, w2, w3} = k;
      t  = {sbox_t[w3[23:16]], sbox_t[w3[15:8]], sbox_t[w3[7:0]], sbox_t[w3[31:24]]}
           ^ {rc, 24'h000000};
      n0 = w0 ^ t;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // Bench-side FSM: decides acceptance itself and pushes the expected keys.
   initial forever begin
      exp_t e;
      @(posedge clk);
      if (rst === 1'b1) begin
         m_cnt = 0;
         sbq.delete();
      end else if (m_cnt == 0) begin
         if (start === 1'b1) begin
            m_k = cipher_key;
            for (int i = 0; i < 11; i++) begin
               e.idx = 4'(i);
               e.key = m_k;
               sbq.push_back(e);
               if (i < 10) m_k = model_next(m_k, rcon_t[i]);
            end
            m_cnt = 11;
         end
      end else begin
         m_cnt--;
      end
   end

   // Monitor: compares DUT outputs against the scoreboard every cycle.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (mon_en) begin
         check("busy", {127'b0, busy}, {127'b0, (m_cnt > 0)});
         check("rk_valid", {127'b0, rk_valid}, {127'b0, (m_cnt > 0)});
         if (rk_valid === 1'b1) begin
            if (sbq.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL sb_empty: rk_valid with rk_idx=%0d but no key expected", rk_idx);
            end else begin
               e = sbq.pop_front();
               check("rk_idx", {124'b0, rk_idx}, {124'b0, e.idx});
               check("round_key", round_key, e.key);
               check("done", {127'b0, done}, {127'b0, (e.idx == 4'd10)});
            end
            if (rk_idx < 4'd11) cap[rk_idx] = round_key;
         end else begin
            check("done_idle", {127'b0, done}, 128'd0);
         end
      end
   end

   task automatic wait_idle();
      int n;
      for (n = 0; n < 40; n++) begin
         if (m_cnt == 0) break;
         @(negedge clk);
      end
      if (m_cnt != 0) check("idle_timeout", 128'd1, 128'd0);
   endtask

   task automatic start_run(input logic [127:0] key);
      wait_idle();
      for (int i = 0; i < 11; i++) cap[i] = 'x;
      start      = 1'b1;
      cipher_key = key;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(output int n_at);
      n_at = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            n_at = n;
            break;
         end
      end
   endtask

   task automatic wait_for_idx(input logic [3:0] idx);
      bit hit;
      hit = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (rk_valid === 1'b1 && rk_idx === idx) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) check("idx_timeout", 128'd0, {124'b0, idx});
   endtask

   task automatic run_key(input logic [127:0] key, output int n_at);
      start_run(key);
      wait_done(n_at);
      @(negedge clk);
   endtask

   initial begin
      int d;
      int dcount;
      build_sbox();
      rcon_t  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
      vecs[0] = '{FIPS_KEY, FIPS_RK1, FIPS_RK10};
      vecs[1] = '{128'd0, 128'h62636363626363636263636362636363, ZERO_RK10};

      rst        = 1'b1;
      start      = 1'b0;
      cipher_key = '0;
`ifdef AES_KEY_STORE_EN
      rk_rd_idx  = 4'd0;
`endif
      repeat (2) @(negedge clk);
      check("rst_busy", {127'b0, busy}, 128'd0);
      check("rst_rk_valid", {127'b0, rk_valid}, 128'd0);
      check("rst_done", {127'b0, done}, 128'd0);
      check("rst_rk_idx", {124'b0, rk_idx}, 128'd0);
      check("rst_round_key", round_key, 128'd0);
      rst    = 1'b0;
      mon_en = 1'b1;

      // Published vectors: rk1, rk10 and done latency.
      for (int v = 0; v < 2; v++) begin
         run_key(vecs[v].key, d);
         check("done_cycle", 128'(d), 128'd11);
         check("vec_rk1", cap[1], vecs[v].rk1);
         check("vec_rk10", cap[10], vecs[v].rk10);
      end

      // Random keys, checked by the scoreboard alone.
      for (int r = 0; r < 3; r++) begin
         run_key({$urandom, $urandom, $urandom, $urandom}, d);
         check("rand_done_cycle", 128'(d), 128'd11);
      end

      // cipher_key changes mid-expansion must not matter.
      start_run(FIPS_KEY);
      wait_for_idx(4'd3);
      cipher_key = '1;
      wait_done(d);
      @(negedge clk);
      check("keychg_rk10", cap[10], FIPS_RK10);

      // start held high: one idle cycle between done and next rk_idx 0.
      wait_idle();
      cipher_key = '0;
      start      = 1'b1;
      wait_done(d);
      @(negedge clk);
      check("b2b_gap_valid", {127'b0, rk_valid}, 128'd0);
      @(negedge clk);
      check("b2b_restart_valid", {127'b0, rk_valid}, 128'd1);
      check("b2b_restart_idx", {124'b0, rk_idx}, 128'd0);
      start = 1'b0;
      wait_done(d);
      check("b2b_second_done", 128'(d), 128'd10);
      @(negedge clk);
      check("b2b_rk10", cap[10], ZERO_RK10);

      // Reset mid-expansion aborts without a done pulse.
      start_run(FIPS_KEY);
      wait_for_idx(4'd5);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", {127'b0, busy}, 128'd0);
      check("abort_rk_valid", {127'b0, rk_valid}, 128'd0);
      check("abort_round_key", round_key, 128'd0);
      check("abort_rk_idx", {124'b0, rk_idx}, 128'd0);
      rst    = 1'b0;
      dcount = 0;
      repeat (15) begin
         @(negedge clk);
         if (done === 1'b1 || rk_valid === 1'b1) dcount++;
      end
      check("abort_no_activity", 128'(dcount), 128'd0);
      run_key(FIPS_KEY, d);
      check("post_abort_done_cycle", 128'(d), 128'd11);
      check("post_abort_rk1", cap[1], FIPS_RK1);
      check("post_abort_rk10", cap[10], FIPS_RK10);

`ifdef AES_KEY_STORE_EN
      rk_rd_idx = 4'd10;
      #1 check("store_rd10", rk_rd_data, FIPS_RK10);
      rk_rd_idx = 4'd1;
      #1 check("store_rd1", rk_rd_data, FIPS_RK1);
      rk_rd_idx = 4'd12;
      #1 check("store_rd12", rk_rd_data, 128'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      rk_rd_idx = 4'd0;
      #1 check("store_rd0_after_rst", rk_rd_data, 128'd0);
`endif

      wait_idle();
      check("sb_drain", 128'(sbq.size()), 128'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
